// File: rtl/fifo_pack_pkg.sv
// Shared constants and helpers for the read-side FIFO word packer.
package fifo_pack_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int PACK_DEF       = 4;

    // Lane-valid mask with the low cnt lanes set.
    function automatic int unsigned keep_mask(input int unsigned cnt);
        return (32'd1 << cnt) - 32'd1;
    endfunction

endpackage

// File: rtl/fifo_word_packer.sv
// Pops bytes from the dual-clock FIFO read port and packs PACK of them
// little-endian into one stream word; a flush pulse emits a partial word.
module fifo_word_packer
    import fifo_pack_pkg::*;
#(
    parameter  int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter  int PACK       = PACK_DEF,
    localparam int OUT_WIDTH  = DATA_WIDTH * PACK
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  flush,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [OUT_WIDTH-1:0]  m_data,
    output logic [PACK-1:0]       m_keep,
    output logic                  m_last
);

    localparam int               CNT_W    = $clog2(PACK + 1);
    localparam logic [CNT_W-1:0] PACK_CNT = CNT_W'(PACK);

    logic [DATA_WIDTH-1:0] acc      [PACK];
    logic [DATA_WIDTH-1:0] acc_next [PACK];
    logic [CNT_W-1:0]      acc_cnt;
    logic [CNT_W-1:0]      fill;
    logic                  inflight;
    logic                  flush_pend;
    logic                  out_free;
    logic                  word_done;
    logic                  flush_fire;
    logic                  flush_emit;
    logic [PACK-1:0]       lane_keep;
    logic [OUT_WIDTH-1:0]  word_next;

    assign out_free = !m_valid || m_ready;

    // Bytes held plus the byte landing this edge; never exceeds PACK.
    assign fill = acc_cnt + CNT_W'(inflight);

    // The top-off pop is only allowed when the completing word can leave
    // on the same edge, so a landing never collides with a held full word.
    assign fifo_rd_en = !rd_rst && !fifo_empty && !flush_pend &&
                        ((fill < PACK_CNT) ||
                         ((fill == PACK_CNT) && inflight && out_free));

    assign word_done  = (fill == PACK_CNT) && out_free;
    assign flush_fire = flush_pend && !inflight && (acc_cnt < PACK_CNT) && out_free;
    assign flush_emit = flush_fire && (acc_cnt != '0);

    always_comb begin
        for (int i = 0; i < PACK; i++) begin
            acc_next[i] = acc[i];
            if (inflight && (acc_cnt == CNT_W'(i))) begin
                acc_next[i] = fifo_rd_data;
            end
        end
    end

    // Partial words zero their unused lanes so stale bytes never leak out.
    always_comb begin
        lane_keep = word_done ? {PACK{1'b1}} : PACK'(keep_mask(32'(acc_cnt)));
        word_next = '0;
        for (int i = 0; i < PACK; i++) begin
            if (lane_keep[i]) begin
                word_next[i*DATA_WIDTH +: DATA_WIDTH] = acc_next[i];
            end
        end
    end

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            for (int i = 0; i < PACK; i++) begin
                acc[i] <= '0;
            end
            acc_cnt    <= '0;
            inflight   <= 1'b0;
            flush_pend <= 1'b0;
            m_valid    <= 1'b0;
            m_data     <= '0;
            m_keep     <= '0;
            m_last     <= 1'b0;
        end else begin
            inflight <= fifo_rd_en;
            for (int i = 0; i < PACK; i++) begin
                acc[i] <= acc_next[i];
            end

            if (word_done) begin
                m_valid <= 1'b1;
                m_data  <= word_next;
                m_keep  <= lane_keep;
                m_last  <= 1'b0;
                acc_cnt <= '0;
            end else if (flush_emit) begin
                m_valid <= 1'b1;
                m_data  <= word_next;
                m_keep  <= lane_keep;
                m_last  <= 1'b1;
                acc_cnt <= '0;
            end else begin
                acc_cnt <= fill;
                if (m_ready) begin
                    m_valid <= 1'b0;
                end
            end

            // A pulse arriving while a flush is pending is absorbed.
            if (flush_fire) begin
                flush_pend <= 1'b0;
            end else if (flush) begin
                flush_pend <= 1'b1;
            end
        end
    end

endmodule
